fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL set the first fetch byte address after reset; it SHALL be word-aligned.
REQ-002 Parameter ADDR_W, default 8, SHALL set the byte-address width (64-word instruction memory).
REQ-003 clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 stall  in  1  SHALL mean decode cannot accept the presented instruction; hold it.
REQ-006 jump  in  1  SHALL be a jump redirect request, valid for one cycle.
REQ-007 jump_target  in  ADDR_W  SHALL be the jump byte address.
REQ-008 branch_taken  in  1  SHALL be a taken-branch redirect request, valid for one cycle.
REQ-009 branch_target  in  ADDR_W  SHALL be the branch byte address.
REQ-010 imem_req  out  1  SHALL be the fetch request to instruction memory.
REQ-011 imem_addr  out  ADDR_W  SHALL be the fetch byte address.
REQ-012 imem_ack  in  1  SHALL mean imem_rdata is valid this cycle.
REQ-013 imem_rdata  in  32  SHALL be the fetched instruction word.
REQ-014 instr  out  32  SHALL be the instruction presented to decode.
REQ-015 instr_pc  out  ADDR_W  SHALL be the byte address of instr.
REQ-016 instr_valid  out  1  SHALL qualify instr and instr_pc.
REQ-017 misaligned  out  1  SHALL be a sticky flag for a rejected non-word-aligned target.

Function
REQ-018 States SHALL be IDLE, REQ, VALID; IDLE is entered only by reset.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then go to REQ with pc = RESET_PC.
REQ-020 In REQ, imem_req SHALL be 1 and imem_addr = pc; both SHALL stay stable until imem_ack is sampled 1.
REQ-021 On imem_ack in REQ with no kill pending: instr <= imem_rdata, instr_pc <= pc, pc <= pc + 4, next state VALID.
REQ-022 instr_valid SHALL be 1 exactly while in VALID; instr and instr_pc SHALL not change while in VALID.
REQ-023 In VALID with stall = 0 and no redirect, next state SHALL be REQ at the already-incremented pc (one-cycle bubble per fetch).
REQ-024 In VALID with stall = 1 and no redirect, the state SHALL remain VALID with all outputs held.
REQ-025 pc + 4 SHALL wrap modulo 2^ADDR_W (8'hFC + 4 = 8'h00) without a flag.
REQ-026 Redirect priority SHALL be jump over branch_taken over sequential; the losing request is dropped.
REQ-027 A redirect in VALID (stall ignored) SHALL set pc = target, clear instr_valid next cycle, and go to REQ.
REQ-028 A redirect in REQ SHALL set kill and latch the target without disturbing imem_addr; the pending fetch SHALL complete.
REQ-029 On imem_ack with kill set, or with a redirect in the same cycle, data SHALL be discarded, kill cleared, pc = target, and the state SHALL stay REQ.
REQ-030 A later redirect while kill is set SHALL overwrite the latched target.
REQ-031 A target with bits [1:0] != 0 SHALL be ignored as if absent and SHALL set misaligned = 1 until reset.
REQ-032 Redirects in IDLE SHALL be ignored.

Reset
REQ-033 While reset_n = 0: state IDLE, pc = RESET_PC, kill = 0, imem_req = 0, imem_addr = RESET_PC, instr = 0, instr_pc = 0, instr_valid = 0, misaligned = 0, independent of clock.
REQ-034 Reset asserted during an outstanding fetch SHALL abandon it; an imem_ack arriving after release SHALL be ignored until the first REQ cycle.

Verification
REQ-035 Reset release, imem_ack one cycle after each imem_req, rdata = addr -> imem_addr sequence 00, 04, 08; instr_valid pulses with instr_pc 00, 04, 08.
REQ-036 stall = 1 for 3 cycles while instr_pc = 04 -> instr_valid held 3 extra cycles, no imem_req; next fetch at 08.
REQ-037 jump = 1 with target 40 and branch_taken = 1 with target 80 in the same VALID cycle -> next fetch at 40.
REQ-038 branch_taken with target 20 during a REQ whose imem_ack is delayed 3 cycles -> imem_addr stays stable, returned data discarded, next fetch at 20, no instr_valid for the killed fetch.
REQ-039 jump target 8'h42 -> misaligned = 1, sequential fetch continues; pc at FC -> next fetch 00.
REQ-040 reset_n pulsed low mid-REQ -> all outputs at reset values immediately; first fetch after release at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: decode-side control, redirect requests and the
// instruction-memory handshake grouped in one bundle.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 8
);
    // Decode side
    logic              stall;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;

    // Redirect requests
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              misaligned;

    // Instruction memory
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    // The fetch sequencer itself
    modport slave (
        input  stall, jump, jump_target, branch_taken, branch_target,
               imem_ack, imem_rdata,
        output imem_req, imem_addr, instr, instr_pc, instr_valid, misaligned
    );

    // The environment: decode, branch unit and instruction memory
    modport master (
        output stall, jump, jump_target, branch_taken, branch_target,
               imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, misaligned
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding fetch at a time, one-cycle
// bubble per instruction, jump/branch redirects with kill of an in-flight
// fetch, and a sticky flag for rejected misaligned targets.
// RESET_PC must be word-aligned.
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    fetch_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic              r_kill, w_kill_next;
    logic [ADDR_W-1:0] r_kill_target, w_kill_target_next;
    logic [31:0]       r_instr, w_instr_next;
    logic [ADDR_W-1:0] r_instr_pc, w_instr_pc_next;
    logic              r_misaligned, w_misaligned_next;

    logic              w_active;
    logic              w_jump_ok, w_branch_ok, w_target_bad;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;

    // Redirect qualification: misaligned targets behave as if absent, and
    // nothing is accepted in IDLE; jump outranks branch.
    always_comb begin
        w_active     = (r_state != IDLE);
        w_jump_ok    = w_active && bus.jump &&
                       (bus.jump_target[1:0] == 2'b00);
        w_branch_ok  = w_active && bus.branch_taken &&
                       (bus.branch_target[1:0] == 2'b00);
        w_target_bad = w_active &&
                       ((bus.jump && (bus.jump_target[1:0] != 2'b00)) ||
                        (bus.branch_taken && (bus.branch_target[1:0] != 2'b00)));
        w_redirect   = w_jump_ok || w_branch_ok;
        w_target     = w_jump_ok ? bus.jump_target : bus.branch_target;
    end

    // Next-state and datapath update for the fetch FSM.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_kill_next        = r_kill;
        w_kill_target_next = r_kill_target;
        w_instr_next       = r_instr;
        w_instr_pc_next    = r_instr_pc;
        w_misaligned_next  = r_misaligned || w_target_bad;

        case (r_state)
            IDLE: begin
                // Any stray ack from a fetch abandoned by reset is ignored.
                w_state_next = REQ;
            end

            REQ: begin
                if (bus.imem_ack) begin
                    if (r_kill || w_redirect) begin
                        // Drop the returned word and restart at the newest target.
                        w_pc_next    = w_redirect ? w_target : r_kill_target;
                        w_kill_next  = 1'b0;
                        w_state_next = REQ;
                    end else begin
                        w_instr_next    = bus.imem_rdata;
                        w_instr_pc_next = r_pc;
                        w_pc_next       = r_pc + ADDR_W'(4);
                        w_state_next    = VALID;
                    end
                end else if (w_redirect) begin
                    // Address must stay stable until the ack, so park the target.
                    w_kill_next        = 1'b1;
                    w_kill_target_next = w_target;
                end
            end

            VALID: begin
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = REQ;
                end else if (!bus.stall) begin
                    w_state_next = REQ;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Program counter, kill bookkeeping, presented instruction and sticky flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_kill_target <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_kill        <= w_kill_next;
            r_kill_target <= w_kill_target_next;
            r_instr       <= w_instr_next;
            r_instr_pc    <= w_instr_pc_next;
            r_misaligned  <= w_misaligned_next;
        end
    end

    // The fetch address is the pc itself; it only moves on an ack or redirect.
    assign bus.imem_req    = (r_state == REQ);
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = (r_state == VALID);
    assign bus.misaligned  = r_misaligned;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_fetch_sequencer;

    localparam int ADDR_W = 8;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (8'h00)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge while in REQ: checks the request, acks it
    // with the given word, and checks the presented instruction one cycle on.
    task automatic do_fetch(input logic [7:0] addr, input logic [31:0] data);
        check("req_asserted", 32'(bus.imem_req), 32'd1);
        check("req_addr", 32'(bus.imem_addr), 32'(addr));
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        @(negedge clock);
        bus.imem_ack   = 1'b0;
        check("valid_set", 32'(bus.instr_valid), 32'd1);
        check("valid_pc", 32'(bus.instr_pc), 32'(addr));
        check("valid_instr", bus.instr, data);
        check("valid_no_req", 32'(bus.imem_req), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_addr"}, 32'(bus.imem_addr), 32'h00);
        check({tag, "_instr"}, bus.instr, 32'h0);
        check({tag, "_instr_pc"}, 32'(bus.instr_pc), 32'h00);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_misaligned"}, 32'(bus.misaligned), 32'd0);
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        reset_n            = 1'b0;
        bus.stall          = 1'b0;
        bus.jump           = 1'b0;
        bus.jump_target    = '0;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = '0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;

        // Reset values before any clock edge.
        #3;
        check_reset_values("por");

        // Release with a stray ack present: IDLE must ignore it.
        repeat (2) @(negedge clock);
        reset_n        = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        bus.imem_ack   = 1'b0;
        check("idle_ack_ignored", 32'(bus.instr_valid), 32'd0);

        // Sequential fetch 00, 04 with rdata = addr.
        do_fetch(8'h00, 32'h0000_0000);
        @(negedge clock);
        do_fetch(8'h04, 32'h0000_0004);

        // Stall three cycles while presenting 04.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_valid", 32'(bus.instr_valid), 32'd1);
            check("stall_pc", 32'(bus.instr_pc), 32'h04);
            check("stall_instr", bus.instr, 32'h0000_0004);
            check("stall_no_req", 32'(bus.imem_req), 32'd0);
        end
        bus.stall = 1'b0;
        @(negedge clock);
        do_fetch(8'h08, 32'h0000_0008);

        // Jump and branch together in VALID: jump wins.
        bus.jump          = 1'b1;
        bus.jump_target   = 8'h40;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h80;
        @(negedge clock);
        bus.jump          = 1'b0;
        bus.branch_taken  = 1'b0;
        check("jump_valid_cleared", 32'(bus.instr_valid), 32'd0);
        do_fetch(8'h40, 32'h0000_0040);

        // Branch during a REQ whose ack is delayed three cycles.
        @(negedge clock);
        check("kill_req_addr0", 32'(bus.imem_addr), 32'h44);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h20;
        @(negedge clock);
        bus.branch_taken  = 1'b0;
        check("kill_req_addr1", 32'(bus.imem_addr), 32'h44);
        check("kill_req_held1", 32'(bus.imem_req), 32'd1);
        @(negedge clock);
        check("kill_req_addr2", 32'(bus.imem_addr), 32'h44);
        @(negedge clock);
        check("kill_req_addr3", 32'(bus.imem_addr), 32'h44);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0000_0044;
        @(negedge clock);
        bus.imem_ack   = 1'b0;
        check("killed_no_valid", 32'(bus.instr_valid), 32'd0);
        check("killed_instr_kept", bus.instr, 32'h0000_0040);
        do_fetch(8'h20, 32'h0000_0020);

        // Misaligned jump is ignored and flagged; sequential fetch continues.
        bus.jump        = 1'b1;
        bus.jump_target = 8'h42;
        @(negedge clock);
        bus.jump        = 1'b0;
        check("misaligned_flag", 32'(bus.misaligned), 32'd1);
        do_fetch(8'h24, 32'h0000_0024);

        // Jump to FC, then the pc wraps to 00.
        bus.jump        = 1'b1;
        bus.jump_target = 8'hFC;
        @(negedge clock);
        bus.jump        = 1'b0;
        do_fetch(8'hFC, 32'h0000_00FC);
        @(negedge clock);
        check("wrap_addr", 32'(bus.imem_addr), 32'h00);
        check("wrap_req", 32'(bus.imem_req), 32'd1);
        check("misaligned_sticky", 32'(bus.misaligned), 32'd1);

        // Reset pulse mid-REQ: outputs drop immediately, late ack ignored.
        #2;
        reset_n        = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0000_0055;
        #1;
        check_reset_values("mid_req_reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_reset_ack_ignored", 32'(bus.instr_valid), 32'd0);
        check("post_reset_misaligned", 32'(bus.misaligned), 32'd0);
        do_fetch(8'h00, 32'h0000_00AB);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
